// File: rtl/mips_mem_pkg.sv
// Shared encodings and helpers for the MEM-stage load/store unit.
package mips_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RMW_RD,
    ST_WRITE,
    ST_RESP
  } state_t;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        is_unsigned;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  // Byte address to word index, i.e. {2'b00, addr[31:2]}.
  function automatic logic [31:0] word_index(input logic [31:0] addr);
    return addr >> 2;
  endfunction

endpackage

// File: rtl/lane_align.sv
// Little-endian lane handling: load extract/extend and sub-word store merge.
module lane_align
  import mips_mem_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = rd_word[{addr_lo, 3'b000} +: 8];
    half_lane = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];
    load_data = '0;
    case (size)
      SZ_BYTE: load_data = {{24{byte_lane[7] & ~is_unsigned}}, byte_lane};
      SZ_HALF: load_data = {{16{half_lane[15] & ~is_unsigned}}, half_lane};
      SZ_WORD: load_data = rd_word;
      default: load_data = '0;
    endcase
  end

  // Only the addressed lane is replaced; the rest comes from the prior read.
  always_comb begin
    merged = old_word;
    case (size)
      SZ_BYTE: merged[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      SZ_HALF: begin
        if (addr_lo[1]) merged[31:16] = wdata[15:0];
        else            merged[15:0]  = wdata[15:0];
      end
      SZ_WORD: merged = wdata;
      default: merged = old_word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Byte-addressed load/store front end for a word-wide, combinational-read data memory.
module mem_access_unit
  import mips_mem_pkg::*;
#(
  parameter int MEM_WORDS = 100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  state_t      state, state_nxt;
  mem_req_t    req_q;
  logic [31:0] old_word_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        acc;
  logic        acc_err;
  logic [31:0] load_data;
  logic [31:0] merged;

  assign acc = req_valid && req_ready;

  // Priority order matters only for which rule rejects; any hit skips memory.
  always_comb begin
    acc_err = 1'b0;
    if (req_size == SZ_ILL)
      acc_err = 1'b1;
    else if (req_size == SZ_HALF && req_addr[0])
      acc_err = 1'b1;
    else if (req_size == SZ_WORD && req_addr[1:0] != 2'b00)
      acc_err = 1'b1;
    else if (word_index(req_addr) >= 32'(MEM_WORDS))
      acc_err = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (acc) begin
          if (acc_err)                 state_nxt = ST_RESP;
          else if (!req_we)            state_nxt = ST_LOAD;
          else if (req_size == SZ_WORD) state_nxt = ST_WRITE;
          else                         state_nxt = ST_RMW_RD;
        end
      end
      ST_LOAD:   state_nxt = ST_RESP;
      ST_RMW_RD: state_nxt = ST_WRITE;
      ST_WRITE:  state_nxt = ST_RESP;
      ST_RESP:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  lane_align u_lane (
    .rd_word     (mem_rd),
    .addr_lo     (req_q.addr[1:0]),
    .size        (req_q.size),
    .is_unsigned (req_q.is_unsigned),
    .old_word    (old_word_q),
    .wdata       (req_q.wdata),
    .load_data   (load_data),
    .merged      (merged)
  );

  // resp_rdata only changes on the edge entering RESP, so it holds between responses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_q      <= '0;
      old_word_q <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      if (acc) begin
        req_q <= '{we: req_we, size: req_size, is_unsigned: req_unsigned,
                   addr: req_addr, wdata: req_wdata};
        err_q <= acc_err;
        if (acc_err) rdata_q <= '0;
      end
      if (state == ST_RMW_RD) old_word_q <= mem_rd;
      if (state == ST_LOAD)   rdata_q    <= load_data;
      if (state == ST_WRITE)  rdata_q    <= '0;
    end
  end

  assign req_ready  = (state == ST_IDLE);
  assign busy       = (state != ST_IDLE);
  assign resp_valid = (state == ST_RESP);
  assign resp_err   = err_q;
  assign resp_rdata = rdata_q;

  // Decoded from state so an asynchronous reset kills the write strobe at once.
  assign mem_we   = (state == ST_WRITE) && req_q.we;
  assign mem_addr = (state == ST_LOAD || state == ST_RMW_RD || state == ST_WRITE)
                    ? word_index(req_q.addr) : 32'h0;
  assign mem_wd   = mem_we ? merged : 32'h0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench: directed plan vectors plus random traffic against a spec-level model.
module tb_mem_access_unit;

  localparam int MEM_WORDS = 100;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err, busy, mem_we;
  logic [31:0] resp_rdata, mem_addr, mem_wd, mem_rd;

  logic [31:0] dmem    [MEM_WORDS];
  logic [31:0] ref_mem [MEM_WORDS];
  logic [31:0] wr_addr_q [$];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .busy(busy), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  assign mem_rd = (mem_addr < MEM_WORDS) ? dmem[mem_addr[6:0]] : 32'h0;

  always @(posedge clk) begin
    if (mem_we) begin
      wr_addr_q.push_back(mem_addr);
      if (mem_addr < MEM_WORDS) dmem[mem_addr[6:0]] <= mem_wd;
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [6:0] widx(input logic [31:0] addr);
    return 7'(addr / 4);
  endfunction

  function automatic bit ref_err(input logic [1:0] size, input logic [31:0] addr);
    if (size == 2'd3) return 1'b1;
    if (size == 2'd1 && (addr % 2) != 0) return 1'b1;
    if (size == 2'd2 && (addr % 4) != 0) return 1'b1;
    if ((addr / 4) >= MEM_WORDS) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] size, input bit uns,
                                           input logic [31:0] addr);
    logic [31:0] w, v;
    w = ref_mem[widx(addr)];
    v = w;
    if (size == 2'd0) begin
      v = (w >> (8 * (addr % 4))) & 32'hFF;
      if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (size == 2'd1) begin
      v = (w >> (16 * ((addr / 2) % 2))) & 32'hFFFF;
      if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] old, input logic [1:0] size,
                                            input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] mask;
    int sh;
    if (size == 2'd2) return wdata;
    if (size == 2'd0) begin
      sh = 8 * int'(addr % 4);
      mask = 32'hFF << sh;
    end else begin
      sh = 16 * int'((addr / 2) % 2);
      mask = 32'hFFFF << sh;
    end
    return (old & ~mask) | ((wdata << sh) & mask);
  endfunction

  // ---------------- driver ----------------
  task automatic run_req(input bit we, input logic [1:0] size, input bit uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic err, output int lat,
                         output int nwe, output logic [31:0] waddr, output logic [31:0] wwd,
                         output bit to);
    int n;
    rdata = 'x; err = 1'bx; lat = 0; nwe = 0; waddr = 'x; wwd = 'x; to = 1'b1;
    @(negedge clk);
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (mem_we) begin
        nwe++;
        waddr = mem_addr;
        wwd = mem_wd;
      end
      if (resp_valid) begin
        lat = c; rdata = resp_rdata; err = resp_err; to = 1'b0;
        break;
      end
    end
  endtask

  typedef struct {
    bit          we;
    logic [1:0]  size;
    bit          uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  // ---------------- tests ----------------
  task automatic test_reset;
    reset = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({req_ready, busy, resp_valid, resp_err, mem_we} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_ctrl: got ready/busy/rv/err/we=%b want 10000",
               {req_ready, busy, resp_valid, resp_err, mem_we});
    end
    checks++;
    if (resp_rdata !== 32'h0 || mem_addr !== 32'h0 || mem_wd !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: rdata=%h addr=%h wd=%h want all 0", resp_rdata, mem_addr, mem_wd);
    end
    reset = 1'b1;
  endtask

  task automatic test_directed;
    vec_t v[$];
    logic [31:0] rd, wa, wd;
    logic er;
    int lat, nwe;
    bit to;
    v.push_back('{0, 2'd2, 0, 32'h0, 32'h0, 32'h0000_0000, 2});
    v.push_back('{1, 2'd2, 0, 32'h8, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 2});
    v.push_back('{0, 2'd2, 0, 32'h8, 32'h0, 32'hDEAD_BEEF, 2});
    v.push_back('{1, 2'd0, 0, 32'h9, 32'h12, 32'hDEAD_12EF, 3});
    v.push_back('{0, 2'd0, 0, 32'h9, 32'h0, 32'h0000_0012, 2});
    v.push_back('{0, 2'd0, 0, 32'hB, 32'h0, 32'hFFFF_FFDE, 2});
    v.push_back('{0, 2'd0, 1, 32'hB, 32'h0, 32'h0000_00DE, 2});
    v.push_back('{0, 2'd1, 0, 32'hA, 32'h0, 32'hFFFF_DEAD, 2});
    v.push_back('{0, 2'd1, 1, 32'hA, 32'h0, 32'h0000_DEAD, 2});
    foreach (v[i]) begin
      run_req(v[i].we, v[i].size, v[i].uns, v[i].addr, v[i].wdata, rd, er, lat, nwe, wa, wd, to);
      checks++;
      if (to || lat != v[i].lat || er !== 1'b0) begin
        errors++;
        $display("FAIL dir%0d_resp: timeout=%0d lat=%0d err=%b want lat=%0d err=0",
                 i, to, lat, er, v[i].lat);
      end
      if (v[i].we) begin
        checks++;
        if (nwe != 1 || wa !== (v[i].addr >> 2) || wd !== v[i].exp || rd !== 32'h0) begin
          errors++;
          $display("FAIL dir%0d_store: nwe=%0d addr=%h wd=%h rdata=%h want 1/%h/%h/0",
                   i, nwe, wa, wd, rd, v[i].addr >> 2, v[i].exp);
        end
        ref_mem[widx(v[i].addr)] = v[i].exp;
      end else begin
        checks++;
        if (nwe != 0 || rd !== v[i].exp) begin
          errors++;
          $display("FAIL dir%0d_load: nwe=%0d rdata=%h want 0/%h", i, nwe, rd, v[i].exp);
        end
      end
    end
  endtask

  task automatic test_errors;
    vec_t v[$];
    logic [31:0] rd, wa, wd;
    logic er;
    int lat, nwe;
    bit to;
    v.push_back('{0, 2'd2, 0, 32'h6,   32'h0, 32'h0, 1});
    v.push_back('{1, 2'd1, 0, 32'h3,   32'h5555, 32'h0, 1});
    v.push_back('{0, 2'd3, 0, 32'h0,   32'h0, 32'h0, 1});
    v.push_back('{0, 2'd2, 0, 32'h190, 32'h0, 32'h0, 1});
    v.push_back('{1, 2'd0, 0, 32'h193, 32'h77, 32'h0, 1});
    foreach (v[i]) begin
      run_req(v[i].we, v[i].size, v[i].uns, v[i].addr, v[i].wdata, rd, er, lat, nwe, wa, wd, to);
      checks++;
      if (to || lat != 1 || er !== 1'b1 || rd !== 32'h0 || nwe != 0) begin
        errors++;
        $display("FAIL err%0d: timeout=%0d lat=%0d err=%b rdata=%h nwe=%0d want lat=1 err=1 rdata=0 nwe=0",
                 i, to, lat, er, rd, nwe);
      end
    end
  endtask

  task automatic test_back_to_back;
    int accepts, resps, ready_bad;
    int acc_cyc [2];
    int resp_cyc [2];
    bit will;
    wr_addr_q.delete();
    accepts = 0; resps = 0; ready_bad = 0;
    acc_cyc[0] = -1; acc_cyc[1] = -1; resp_cyc[0] = -1; resp_cyc[1] = -1;
    @(negedge clk);
    req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h1; req_valid = 1'b1;
    for (int c = 0; c < 30; c++) begin
      will = req_ready;
      if (req_ready === busy) ready_bad++;
      if (resp_valid) begin
        if (resps < 2) resp_cyc[resps] = c;
        resps++;
      end
      if (resps >= 2) break;
      @(posedge clk);
      @(negedge clk);
      if (will && req_valid) begin
        if (accepts < 2) acc_cyc[accepts] = c;
        accepts++;
        if (accepts == 1) begin
          req_addr = 32'h4; req_wdata = 32'h2;
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    req_valid = 1'b0;
    ref_mem[0] = 32'h1;
    ref_mem[1] = 32'h2;
    checks++;
    if (ready_bad != 0) begin
      errors++;
      $display("FAIL b2b_ready_busy: %0d cycles with req_ready==busy, want 0", ready_bad);
    end
    checks++;
    if (accepts != 2 || resps != 2 || acc_cyc[1] <= resp_cyc[0]) begin
      errors++;
      $display("FAIL b2b_order: accepts=%0d resps=%0d acc2=%0d resp1=%0d want 2/2 acc2>resp1",
               accepts, resps, acc_cyc[1], resp_cyc[0]);
    end
    checks++;
    if (wr_addr_q.size() != 2 || wr_addr_q[0] !== 32'h0 || wr_addr_q[1] !== 32'h1) begin
      errors++;
      $display("FAIL b2b_writes: %0d writes, want 2 in order idx 0 then 1", wr_addr_q.size());
    end
    checks++;
    if (dmem[0] !== ref_mem[0] || dmem[1] !== ref_mem[1]) begin
      errors++;
      $display("FAIL b2b_mem: mem0=%h mem1=%h want %h %h", dmem[0], dmem[1], ref_mem[0], ref_mem[1]);
    end
  endtask

  task automatic test_reset_mid_write;
    logic [31:0] rd, wa, wd;
    logic er;
    int lat, nwe, rv_seen;
    bit to, seen;
    run_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h1122_3344, rd, er, lat, nwe, wa, wd, to);
    ref_mem[4] = 32'h1122_3344;
    @(negedge clk);
    req_we = 1'b1; req_size = 2'd1; req_unsigned = 1'b0; req_addr = 32'h12;
    req_wdata = 32'hABCD; req_valid = 1'b1;
    @(posedge clk);
    seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (mem_we) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL rst_mid_reach: mem_we never seen for SH, want write phase");
    end
    #1 reset = 1'b0;
    #1;
    checks++;
    if (mem_we !== 1'b0 || resp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_async: we=%b rv=%b busy=%b want 0/0/0", mem_we, resp_valid, busy);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    rv_seen = 0;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_ready: req_ready=%b want 1", req_ready);
    end
    repeat (3) begin
      @(negedge clk);
      if (resp_valid) rv_seen++;
    end
    checks++;
    if (rv_seen != 0 || dmem[4] !== ref_mem[4]) begin
      errors++;
      $display("FAIL rst_mid_mem: resp pulses=%0d mem4=%h want 0 and %h", rv_seen, dmem[4], ref_mem[4]);
    end
    run_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er, lat, nwe, wa, wd, to);
    checks++;
    if (to || er !== 1'b0 || rd !== ref_mem[4]) begin
      errors++;
      $display("FAIL rst_mid_reload: timeout=%0d err=%b rdata=%h want %h", to, er, rd, ref_mem[4]);
    end
  endtask

  task automatic test_random;
    logic [31:0] rd, wa, wd, addr, wdata, exp_rd, exp_wd;
    logic [1:0] size;
    logic er;
    bit we, uns, e_err, to;
    int lat, nwe, exp_lat;
    for (int i = 0; i < 120; i++) begin
      we    = 1'($urandom_range(0, 1));
      uns   = 1'($urandom_range(0, 1));
      size  = 2'($urandom_range(0, 3));
      addr  = 32'($urandom_range(0, 32'h1A3));
      wdata = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (size == 2'd1) addr = addr & ~32'h1;
        if (size == 2'd2) addr = addr & ~32'h3;
      end
      e_err = ref_err(size, addr);
      exp_rd = 32'h0; exp_wd = 32'h0;
      if (e_err)      exp_lat = 1;
      else if (!we)   exp_lat = 2;
      else            exp_lat = (size == 2'd2) ? 2 : 3;
      if (!e_err && !we) exp_rd = ref_load(size, uns, addr);
      if (!e_err && we)  exp_wd = ref_store(ref_mem[widx(addr)], size, addr, wdata);
      run_req(we, size, uns, addr, wdata, rd, er, lat, nwe, wa, wd, to);
      checks++;
      if (to || lat != exp_lat || er !== e_err || rd !== exp_rd) begin
        errors++;
        $display("FAIL rnd%0d_resp: we=%0d sz=%0d a=%h lat=%0d err=%b rd=%h want lat=%0d err=%0d rd=%h",
                 i, we, size, addr, lat, er, rd, exp_lat, e_err, exp_rd);
      end
      checks++;
      if (!e_err && we) begin
        if (nwe != 1 || wa !== (addr >> 2) || wd !== exp_wd) begin
          errors++;
          $display("FAIL rnd%0d_write: nwe=%0d addr=%h wd=%h want 1/%h/%h",
                   i, nwe, wa, wd, addr >> 2, exp_wd);
        end
        ref_mem[widx(addr)] = exp_wd;
      end else if (nwe != 0) begin
        errors++;
        $display("FAIL rnd%0d_nowrite: nwe=%0d want 0", i, nwe);
      end
    end
  endtask

  task automatic test_mem_image;
    for (int i = 0; i < MEM_WORDS; i++) begin
      checks++;
      if (dmem[i] !== ref_mem[i]) begin
        errors++;
        $display("FAIL mem_image[%0d]: got %h want %h", i, dmem[i], ref_mem[i]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < MEM_WORDS; i++) begin
      dmem[i] = 32'h0;
      ref_mem[i] = 32'h0;
    end
    test_reset;
    test_directed;
    test_errors;
    test_back_to_back;
    test_reset_mid_write;
    test_random;
    test_mem_image;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator-side load/store unit that sits between the MIPS MEM stage and the word-wide data memory (WE/A/WD/RD interface, combinational read, word-indexed address).
- Converts byte-addressed LB/LBU/LH/LHU/LW/SB/SH/SW requests into word accesses.
- Performs read-modify-write for sub-word stores and sign/zero-extends loads.
- Flags misaligned, out-of-range and illegal-size accesses without touching memory.

Parameters:
- MEM_WORDS, 100, number of 32-bit words in data memory; word index >= MEM_WORDS is an error.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept request (high only in IDLE)
- req_we  in  1  1=store, 0=load
- req_size  in  2  00=byte, 01=half, 10=word, 11=illegal
- req_unsigned  in  1  zero-extend load (LBU/LHU); ignored for word and stores
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores/errors
- resp_err  out  1  valid with resp_valid; 1 = access rejected
- busy  out  1  FSM not in IDLE
- mem_we  out  1  data memory write enable
- mem_addr  out  32  word index = {2'b00, addr[31:2]}
- mem_wd  out  32  data memory write data
- mem_rd  in  32  data memory read data (combinational from mem_addr)

Behaviour:
- Clock and reset: one clock, clk; reset asynchronous active-low.
- Reset values: state IDLE, req_ready=1, busy=0, resp_valid=0, resp_err=0, resp_rdata=0, mem_we=0, mem_addr=0, mem_wd=0, captured request registers 0.
- Accept: at a rising edge with req_valid && req_ready; all req_* captured. req_valid while busy is ignored; requester must hold it.
- States: IDLE, LOAD, RMW_RD, WRITE, RESP.
- Error check at accept, first match wins:
  - size=11
  - half with addr[0]=1
  - word with addr[1:0]!=0
  - addr[31:2] >= MEM_WORDS
- Transitions:
  - Error: IDLE->RESP, resp_err=1, no memory write.
  - Load: IDLE->LOAD->RESP. In LOAD, mem_addr drives the word index; lane extracted and extended from mem_rd and registered at the end of LOAD.
  - SW: IDLE->WRITE->RESP. mem_wd=req_wdata.
  - SB/SH: IDLE->RMW_RD->WRITE->RESP. The word read in RMW_RD is registered; WRITE merges the new lane into it.
  - RESP->IDLE unconditionally.
- Latency, counted from accept edge to resp_valid cycle:
  - load: 2 cycles
  - SW: 2 cycles
  - SB/SH: 3 cycles
  - error: 1 cycle
  - Next accept is possible on the edge that leaves RESP+1, i.e. req_ready is high in the cycle after RESP.
- Lanes (little-endian):
  - byte k = bits [8k+7:8k], k=addr[1:0]
  - half = bits [15:0] if addr[1]=0, else [31:16]
  - Signed loads replicate the lane MSB; unsigned loads zero-fill.
- mem_we is decoded from state and is high only during WRITE, exactly one cycle per store. mem_addr holds the captured word index in LOAD/RMW_RD/WRITE and 0 otherwise.
- Reset mid-operation forces IDLE immediately. mem_we drops asynchronously; no response is issued. Any write already committed at a prior edge stands.
- resp_rdata holds its value until the next RESP; resp_err is meaningful only with resp_valid.

Decomposition:
- Shared package mips_mem_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD
  - state encoding for the FSM
  - function word_index(addr)
- One natural sub-module, lane_align, pure combinational:
  - load side: extract + extend (inputs: word, addr[1:0], size, unsigned)
  - store side: merge (inputs: old word, wdata, addr[1:0], size)
- The FSM stays in mem_access_unit.

Test Plan:
- Reset then LW addr 0x0 -> resp_valid 2 cycles after accept, resp_rdata=0x00000000, resp_err=0, mem_we never high.
- SW addr 0x8 data 0xDEADBEEF, then LW 0x8 -> mem_we one cycle with mem_addr=2, mem_wd=0xDEADBEEF; load returns 0xDEADBEEF.
- After the above, SB addr 0x9 data 0x12 -> RMW writes 0xDEAD12EF; LB 0x9 -> 0x00000012; LB 0xB -> 0xFFFFFFDE; LBU 0xB -> 0x000000DE; LH 0xA -> 0xFFFFDEAD; LHU 0xA -> 0x0000DEAD.
- LW 0x6, SH 0x3, size=11, LW 0x190 (index 100) -> each resp_err=1 one cycle after accept, resp_rdata=0, no mem_we.
- req_valid held high back-to-back (SW 0x0 0x1, SW 0x4 0x2) -> second accepted only after the first completes; req_ready low while busy=1; both words are written in order.
- Reset asserted during WRITE of SH -> mem_we drops within the same cycle, no resp_valid, req_ready=1 after release, memory word unchanged.
